// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the request-to-send handshake, shifts out the 11-bit frame on the
// device clock, checks the device ACK and reports done/error. Both PS/2 lines
// are driven open-drain through output enables (1 = pull low).
// Optional feature macro: PS2_TX_RETRY_EN re-runs a failed frame up to two
// more times before reporting tx_error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_fail_tgt;
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_clk_prev;
    logic [9:0]       r_shift;
    logic [3:0]       r_bitcnt;
    logic             r_data_oe;
    logic [INH_W-1:0] r_inh;
    logic [TO_W-1:0]  r_to;
    logic             w_clk_s;
    logic             w_data_s;
    logic             w_fall;
    logic             w_accept;
    logic             w_to_hit;
    logic             w_fail;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign w_accept = tx_valid & (r_state == S_IDLE);
    assign w_to_hit = (r_to == TO_W'(TIMEOUT_CYCLES));

    // A fall always beats a simultaneous timeout; a bad ACK is a failure too.
    assign w_fail = ((r_state == S_SEND) & ~w_fall & w_to_hit)
                  | ((r_state == S_ACK) & w_fall & w_data_s)
                  | ((r_state == S_ACK) & ~w_fall & w_to_hit)
                  | ((r_state == S_WAIT_IDLE) & ~(w_clk_s & w_data_s) & w_to_hit);

`ifdef PS2_TX_RETRY_EN
    logic [1:0] r_retry;

    // Count failed attempts of the current byte; the third failure is final.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retry <= 2'd0;
        else if (w_accept)
            r_retry <= 2'd0;
        else if (w_fail && (r_retry != 2'd2))
            r_retry <= r_retry + 2'd1;
    end

    assign w_fail_tgt = (r_retry == 2'd2) ? S_ERROR : S_INHIBIT;
`else
    assign w_fail_tgt = S_ERROR;
`endif

    // Two-flop synchronizers; idle-high reset so no false fall after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; any failure overrides the normal transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (tx_valid) w_next = S_INHIBIT;
            S_INHIBIT:   if (r_inh == INH_W'(INHIBIT_CYCLES - 1)) w_next = S_REQ;
            S_REQ:       w_next = S_SEND;
            S_SEND:      if (w_fall && (r_bitcnt == 4'd9)) w_next = S_ACK;
            S_ACK:       if (w_fall && !w_data_s) w_next = S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_clk_s && w_data_s) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            S_ERROR:     w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (w_fail)
            w_next = w_fail_tgt;
    end

    // Frame shifter, bit counter, inhibit timer and inter-edge timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_data_oe <= 1'b0;
            r_inh     <= '0;
            r_to      <= '0;
        end else begin
            if (w_accept)
                r_shift <= {1'b1, ~^tx_data, tx_data};

            if (r_state == S_INHIBIT)
                r_inh <= r_inh + INH_W'(1);
            else
                r_inh <= '0;

            // Start bit is held from REQ until the first device fall.
            if (r_state == S_REQ) begin
                r_bitcnt  <= '0;
                r_data_oe <= 1'b1;
            end else if ((r_state == S_SEND) && w_fall) begin
                r_data_oe <= ~r_shift[r_bitcnt];
                r_bitcnt  <= r_bitcnt + 4'd1;
            end

            if (r_state == S_REQ)
                r_to <= '0;
            else if (((r_state == S_SEND) || (r_state == S_ACK)) && w_fall)
                r_to <= '0;
            else if ((r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE))
                r_to <= r_to + TO_W'(1);
            else
                r_to <= '0;
        end
    end

    // Moore outputs; decoding from state releases both lines as soon as rst hits.
    always_comb begin
        tx_ready    = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        tx_done     = (r_state == S_DONE);
        tx_error    = (r_state == S_ERROR);
        ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
        ps2_data_oe = (r_state == S_REQ) || ((r_state == S_SEND) && r_data_oe);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model (40-cycle clock
// period, ACK by pulling data low) and a bit scoreboard.
// Build with +define+PS2_TX_RETRY_EN to check the retry variant.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 200;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;
    logic       w_clk_line, w_data_line;

    // Open-drain bus: either side may pull a line low.
    assign w_clk_line  = ~ps2_clk_oe & dev_clk;
    assign w_data_line = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clk_in(w_clk_line), .ps2_data_in(w_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int sd, se;
    logic exp_q[$];

    // Cycle counter and pulse counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected device samples: start, data LSB first, odd parity, stop.
    task automatic push_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            if (b[i]) ones++;
        end
        exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        while (tx_ready !== 1'b1 && g < 2000) begin step(1); g++; end
        check("ready_before_send", tx_ready, 1);
        sd = done_cnt;
        se = err_cnt;
        push_frame(b);
        tx_data  = b;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        check("accept_clk_oe", ps2_clk_oe, 1);
        check("accept_busy", busy, 1);
    endtask

    // Device side of one attempt: measure the inhibit, then clock nfalls bits.
    task automatic dev_frame(input int nfalls, input bit ack_low, output int last_fall);
        int g, low;
        logic smp, e;
        g = 0;
        low = 0;
        last_fall = cyc;
        while (ps2_clk_oe !== 1'b1 && g < 2000) begin step(1); g++; end
        check("rts_seen", ps2_clk_oe, 1);
        while (ps2_clk_oe === 1'b1 && g < 4000) begin low++; step(1); g++; end
        check("clk_oe_low_len", low, INH + 1);
        check("start_held", ps2_data_oe, 1);
        for (int k = 1; k <= nfalls; k++) begin
            step(20);
            smp = w_data_line;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            check($sformatf("bit%0d", k), smp, e);
            if (k == 11) begin
                dev_data_low = ack_low;
                step(5);
            end
            dev_clk = 1'b0;
            last_fall = cyc;
            step((k == 11) ? 2 : 20);
            dev_clk = 1'b1;
            if (k == 11 && ack_low) begin
                step(5);
                dev_data_low = 1'b0;
            end
        end
        exp_q.delete();
    endtask

    task automatic wait_outcome(input int exp_d, input int exp_e);
        int g;
        g = 0;
        while (done_cnt == sd && err_cnt == se && g < 3000) begin step(1); g++; end
        check("outcome_seen", (g < 3000), 1);
        step(3);
        check("done_pulses", done_cnt - sd, exp_d);
        check("error_pulses", err_cnt - se, exp_e);
        check("ready_after", tx_ready, 1);
        check("clk_oe_after", ps2_clk_oe, 0);
        check("data_oe_after", ps2_data_oe, 0);
    endtask

    initial begin
        int lf;
        // Reset state.
        step(3);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        rst = 1'b0;
        step(5);

        // 0xED, acknowledged.
        send(8'hED);
        dev_frame(11, 1'b1, lf);
        wait_outcome(1, 0);

        // 0xF4, acknowledged.
        send(8'hF4);
        dev_frame(11, 1'b1, lf);
        wait_outcome(1, 0);

        // NACK on every attempt.
        send(8'h55);
        for (int a = 0; a < ATTEMPTS; a++) begin
            if (a > 0) push_frame(8'h55);
            dev_frame(11, 1'b0, lf);
        end
        wait_outcome(0, 1);

        // Device stops after 4 bits: timeout from the last fall.
        send(8'hA3);
        for (int a = 0; a < ATTEMPTS; a++) begin
            if (a > 0) push_frame(8'hA3);
            dev_frame(4, 1'b1, lf);
        end
        wait_outcome(0, 1);
        check("timeout_window", (err_cyc - lf >= TO) && (err_cyc - lf <= TO + 10), 1);

        // tx_valid while busy is ignored.
        send(8'hED);
        fork
            dev_frame(11, 1'b1, lf);
            begin
                step(60);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                step(5);
                check("ready_while_busy", tx_ready, 0);
                tx_valid = 1'b0;
            end
        join
        wait_outcome(1, 0);

        // Reset mid-frame while data line is pulled low.
        send(8'hED);
        dev_frame(5, 1'b1, lf);
        check("pre_rst_data_oe", ps2_data_oe, 1);
        sd = done_cnt;
        se = err_cnt;
        #2 rst = 1'b1;
        #1;
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_ready", tx_ready, 1);
        step(3);
        rst = 1'b0;
        step(10);
        check("midrst_no_done", done_cnt - sd, 0);
        check("midrst_no_err", err_cnt - se, 0);

        // Fresh byte after the abandoned one.
        send(8'hED);
        dev_frame(11, 1'b1, lf);
        wait_outcome(1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), from the FPGA to a PS/2 keyboard over the same PS2_CLK/PS2_DATA pair used by the keyboard decoder. The block drives both lines open-drain through output-enable pins; the top level owns the inout tristates. It runs the full request-to-send, 11-bit frame and acknowledge sequence, and reports busy, done and error.

## Interface
- INHIBIT_CYCLES, 10000: clk cycles PS2_CLK is held low before the request (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles allowed between device clock falling edges, or while waiting for idle (20 ms).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; the byte is accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE; keyboard decoder input is ignored while high.
- tx_done  out  1  one-cycle pulse: byte acknowledged and bus idle.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.
- ps2_clk_in, ps2_data_in  in  1  raw pin levels.
- ps2_clk_oe, ps2_data_oe  out  1  1 = drive the line low, 0 = release (Z).

## Operation
- Input conditioning:
  - 2-flop synchronizers on ps2_clk_in and ps2_data_in.
  - fall = synced clock was 1 last cycle and is 0 now.
- On accept:
  - Latch shift register = {1'b1 (stop), ~^tx_data (odd parity), tx_data}.
  - bitcnt = 0.
- States:
  - IDLE: both oe = 0, tx_ready = 1. Accept → INHIBIT.
  - INHIBIT: clk_oe = 1, data_oe = 0 for exactly INHIBIT_CYCLES cycles → REQ.
  - REQ: clk_oe = 1, data_oe = 1 (start bit) for 1 cycle → SEND.
  - SEND: clk_oe = 0. On each fall:
    - bitcnt 0..7: data_oe = ~data[bitcnt], LSB first.
    - bitcnt 8: parity.
    - bitcnt 9: stop, so data_oe = 0.
    - Then bitcnt++. After the fall with bitcnt = 9 → ACK.
  - ACK: both released. On the next fall, sample synced data: 0 → WAIT_IDLE, 1 → ERROR.
  - WAIT_IDLE: wait until synced clk and data are both 1 → DONE.
  - DONE: tx_done = 1 for 1 cycle → IDLE.
  - ERROR: tx_error = 1 for 1 cycle, both oe = 0 → IDLE.
- Timeout counter:
  - Cleared on entry to SEND and on every fall in SEND/ACK.
  - Runs in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES → ERROR.
- Counter widths are $clog2(param+1); no wrap is possible before a state exit.
- tx_valid asserted while busy is ignored, not queued.
- Simultaneous timeout expiry and fall in the same cycle: the fall wins and the counter clears.
- Unexpected falls in INHIBIT or REQ are ignored.

## Timing
- Reset values (asynchronous, immediate):
  - ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, tx_done = 0, tx_error = 0.
  - State IDLE, shift register 0.
- rst asserted mid-frame releases both lines in the same instant, abandons the frame, and produces no done/error pulse.
- Accept edge to ps2_clk_oe = 1: 1 cycle (registered).
- ps2_clk_oe low duration: INHIBIT_CYCLES + 1 cycles. data_oe rises 1 cycle before clk_oe falls.
- Pin falling edge to data_oe update: 3 clk cycles (2 sync + 1 register). This is well inside the ≥5 µs PS/2 half-period.
- tx_done fires 1 cycle after both synced lines read high following a valid ACK.
- tx_ready returns to 1 the cycle after the done/error pulse.
- A back-to-back accept is possible in that cycle.

## Configuration
- PS2_TX_RETRY_EN:
  - Defined: on a timeout or NACK, the block re-runs INHIBIT with the latched byte, up to 2 retries (3 attempts total).
  - tx_error pulses only after the third failure. busy stays high across retries, and no intermediate pulses are produced.
- Undefined: the first failure pulses tx_error and returns to IDLE.

## Test plan
Bench parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 200. A device model clocks at a 40-cycle period and ACKs with data low.
- Send 0xED:
  - clk_oe is low for 21 cycles.
  - Device samples, LSB first: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK given → single tx_done; tx_error stays 0.
- Send 0xF4: samples 0,0,1,0,1,1,1,1, parity 0; tx_done.
- Device answers data = 1 on the ACK edge:
  - Without PS2_TX_RETRY_EN: tx_error pulse, both oe = 0, tx_ready = 1.
  - With PS2_TX_RETRY_EN: 3 full frames, then one tx_error.
- Device stops clocking after 4 bits: tx_error 200 cycles after the last fall; lines released.
- Assert tx_valid while busy with 0xAA: frame still carries the original byte; exactly one tx_done.
- Assert rst during bit 5 (data_oe = 1): both oe = 0 immediately, no pulses. A new 0xED sent after release completes normally.
